iopad_in_filter: RTL



---
 rtl/iopad_pkg.sv | 15 +
 rtl/iopad_in_filter_lane.sv | 117 +++++++++++
 rtl/iopad_in_filter.sv | 36 +++
 3 files changed

// File: rtl/iopad_pkg.sv
// iopad_pkg: shared types and defaults for the pad input filter.
// Lane state encoding plus default synchroniser/debounce depths.
package iopad_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } iopad_lane_state_e;

  localparam int IOPAD_SYNC_STAGES_DEF = 2;
  localparam int IOPAD_DEBOUNCE_DEF    = 4;

endpackage

// File: rtl/iopad_in_filter_lane.sv
// iopad_in_filter_lane: one pad lane -- sync chain, debounce FSM,
// registered clean level and single-cycle edge pulses.
module iopad_in_filter_lane
  import iopad_pkg::*;
#(
  parameter int SYNC_STAGES     = IOPAD_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = IOPAD_DEBOUNCE_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic condition,
  input  logic pad,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  iopad_lane_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              clean_q, clean_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Sync chain keeps running even while the lane is gated off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!condition) begin
      state_d = STABLE_LO;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        STABLE_LO: begin
          if (s) begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
        CHK_HI: begin
          if (!s) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
        CHK_LO: begin
          if (s) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
    clean_d = (state_d == STABLE_HI) || (state_d == CHK_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/iopad_in_filter.sv
// iopad_in_filter: per-pad synchronise + debounce for N_PADS lanes,
// all gated by a shared condition enable.
module iopad_in_filter
  import iopad_pkg::*;
#(
  parameter int N_PADS          = 3,
  parameter int SYNC_STAGES     = IOPAD_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = IOPAD_DEBOUNCE_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              condition,
  input  logic [N_PADS-1:0] fs_in,
  output logic [N_PADS-1:0] fs_clean,
  output logic [N_PADS-1:0] fs_rise,
  output logic [N_PADS-1:0] fs_fall
);

  for (genvar i = 0; i < N_PADS; i++) begin : g_lane
    iopad_in_filter_lane #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .condition (condition),
      .pad       (fs_in[i]),
      .clean     (fs_clean[i]),
      .rise      (fs_rise[i]),
      .fall      (fs_fall[i])
    );
  end

endmodule
